// File: rtl/bs_pkg.sv
// Shared defaults and helpers for the bitstream window buffer.
package bs_pkg;

  localparam int BS_WORD_W = 32;
  localparam int BS_WIN_W  = 48;
  localparam int BS_DEPTH  = 4;
  localparam int BS_PC_W   = 32;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/bs_window_shifter.sv
// Combinational MSB-first window extraction from DEPTH-1 concatenated ring words.
module bs_window_shifter
  import bs_pkg::*;
#(
  parameter int WORD_W = BS_WORD_W,
  parameter int DEPTH  = BS_DEPTH,
  parameter int WIN_W  = BS_WIN_W
) (
  input  logic [(DEPTH-1)*WORD_W-1:0] words,
  input  logic [clog2(WORD_W)-1:0]    off,
  output logic [WIN_W-1:0]            win
);

  localparam int CAT_W = (DEPTH - 1) * WORD_W;

  // Drop the first off bits, then keep the top WIN_W bits of what remains.
  assign win = WIN_W'((words << off) >> (CAT_W - WIN_W));

endmodule

// File: rtl/bs_window_buffer.sv
// Bitstream ring buffer presenting a registered WIN_W-bit window at bit pointer pc.
// Optional macro BS_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module bs_window_buffer
  import bs_pkg::*;
#(
  parameter int WORD_W = BS_WORD_W,
  parameter int DEPTH  = BS_DEPTH,
  parameter int WIN_W  = BS_WIN_W,
  parameter int PC_W   = BS_PC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  input  logic [PC_W-1:0]   pc,
  input  logic              flush,
`ifdef BS_UNDERRUN_CNT_EN
  output logic [15:0]       underrun_cnt,
`endif
  output logic              win_valid,
  output logic [WIN_W-1:0]  win_data
);

  localparam int LW    = clog2(WORD_W);
  localparam int IDX_W = PC_W - LW;
  localparam int AW    = clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int CAT_W = (DEPTH - 1) * WORD_W;

  logic [WORD_W-1:0] ring [DEPTH];
  logic [IDX_W-1:0]  base, w, last, end_idx, base_r, base_n;
  logic [CNT_W-1:0]  count, cnt_r, cnt_n;
  logic [LW-1:0]     off;
  logic [CAT_W-1:0]  cat;
  logic [WIN_W-1:0]  shifted;
  logic              win_cond, accept, keep, we;

  assign w        = pc[PC_W-1:LW];
  assign off      = pc[LW-1:0];
  assign last     = IDX_W'((pc + PC_W'(WIN_W - 1)) >> LW);
  assign end_idx  = base + IDX_W'(count);
  assign in_ready = (count < CNT_W'(DEPTH)) && !flush && !reset;
  assign accept   = in_valid && in_ready;
  assign keep     = (end_idx >= w);
  assign we       = accept && keep;
  assign win_cond = (base <= w) && (end_idx > last);

  // Ring words w, w+1, ... gathered oldest-first into the shifter input.
  for (genvar i = 0; i < DEPTH - 1; i++) begin : g_cat
    logic [AW-1:0] ra;
    assign ra = w[AW-1:0] + AW'(i);
    assign cat[CAT_W-1-i*WORD_W -: WORD_W] = ring[ra];
  end

  bs_window_shifter #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .WIN_W  (WIN_W)
  ) u_shifter (
    .words (cat),
    .off   (off),
    .win   (shifted)
  );

  // Retire everything below w, then apply the accept (write or drop).
  always_comb begin
    base_r = base;
    cnt_r  = count;
    if (w > base) begin
      if (w < end_idx) begin
        base_r = w;
        cnt_r  = count - CNT_W'(w - base);
      end else begin
        base_r = end_idx;
        cnt_r  = '0;
      end
    end
    base_n = base_r;
    cnt_n  = cnt_r;
    if (accept) begin
      if (keep) cnt_n  = cnt_r + 1'b1;
      else      base_n = base_r + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base      <= '0;
      count     <= '0;
      win_valid <= 1'b0;
      win_data  <= '0;
    end else if (flush) begin
      base      <= w;
      count     <= '0;
      win_valid <= 1'b0;
    end else begin
      base      <= base_n;
      count     <= cnt_n;
      win_valid <= win_cond;
      if (win_cond) win_data <= shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (we) ring[end_idx[AW-1:0]] <= in_data;
  end

`ifdef BS_UNDERRUN_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    underrun_cnt <= '0;
    else if (flush)                               underrun_cnt <= '0;
    else if (!win_cond && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif

endmodule
